// File: rtl/mantissa_div_seq.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock, valid/ready
// request and result handshakes, divide-by-zero flagged instead of iterated.
module mantissa_div_seq #(
    parameter  int WIDTH = 24,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Restored partial remainder is always < M, so only WIDTH bits need storing;
    // the sign bit lives in the WIDTH+1-bit trial subtraction below.
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   a_next;
    logic [WIDTH-1:0]   q_next;

    always_comb begin
        shifted = {a_q, qr_q[WIDTH-1]};
        trial   = shifted - {1'b0, m_q};
        a_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next  = {qr_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        qr_d    = qr_q;
        m_d     = m_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        qr_d    = dividend;
                        m_d     = divisor;
                        a_d     = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                a_d   = a_next;
                qr_d  = q_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quo_d   = q_next;
                    rem_d   = a_next;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            qr_q    <= '0;
            m_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            m_q     <= m_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Reset is folded into start_ready so no request is offered while held in reset.
    assign start_ready = (state_q == IDLE) && !rst;
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
